imem_boot_ctrl: RTL and testbench

Boot/run sequencer for the fetch stage. Takes a host word stream, writes it into instruction memory through the fetch stage's write port (`insn_addr`/`insn_din`/`insn_we`), and holds `run` low during the load. It then releases `run` after a settle delay and tracks core completion or host halt. The block sits between the host interface and `instruction_fetch`, and is the only driver of that block's `run` and imem write port.

---
 rtl/mspu_boot_pkg.sv | 16 +
 rtl/imem_boot_ctrl.sv | 159 +++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mspu_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot sequencer.
package mspu_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StRun,
        StHalted
    } boot_state_e;

    localparam logic [31:0] BOOT_BASE_ADDR = 32'h8000_0000;
    localparam int unsigned BOOT_DEPTH     = 12;
    localparam int unsigned BOOT_SETTLE    = 2;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: streams a host image into imem, then releases the fetch
// stage's run after a settle delay and tracks completion or host halt.
module imem_boot_ctrl
    import mspu_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BOOT_BASE_ADDR,
    parameter int unsigned DEPTH     = BOOT_DEPTH,
    parameter int unsigned SETTLE    = BOOT_SETTLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [31:0]      load_len,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    input  logic             halt_req,
    input  logic             core_done,
    output logic [31:0]      insn_addr,
    output logic [31:0]      insn_din,
    output logic             insn_we,
    output logic             run,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [DEPTH:0]   words_loaded
);

    localparam int unsigned CntW   = $clog2(SETTLE + 1);
    localparam logic [32:0] MaxLen = 33'(1) << DEPTH;

    boot_state_e     r_state;
    boot_state_e     w_state_d;
    logic [DEPTH:0]  r_len;
    logic [DEPTH:0]  r_words;
    logic [CntW-1:0] r_cnt;
    logic            r_run;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_din;

    logic            w_ready;
    logic            w_xfer;
    logic            w_start_ok;
    logic            w_too_long;
    logic            w_accept;
    logic [DEPTH:0]  w_words_inc;
    logic [31:0]     w_wr_addr;
    logic            w_unused_len;

    assign w_ready     = (r_state == StLoad) && (r_words < r_len);
    // A word presented in the same cycle as halt_req is dropped with the abort.
    assign w_xfer      = s_valid && w_ready && !halt_req;
    assign w_start_ok  = load_start && !halt_req &&
                         ((r_state == StIdle) || (r_state == StHalted));
    assign w_too_long  = {1'b0, load_len} > MaxLen;
    assign w_accept    = w_start_ok && !w_too_long;
    assign w_words_inc = r_words + (DEPTH + 1)'(1);
    assign w_wr_addr   = BASE_ADDR + (32'(r_words) << 2);
    assign w_unused_len = ^load_len[31:DEPTH+1];

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = (load_len == 32'd0) ? StSettle : StLoad;
                end
            end
            StLoad: begin
                if (halt_req) begin
                    w_state_d = StIdle;
                end else if (w_xfer && (w_words_inc == r_len)) begin
                    w_state_d = StSettle;
                end
            end
            StSettle: begin
                if (halt_req) begin
                    w_state_d = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (halt_req) begin
                    w_state_d = StIdle;
                end else if (core_done) begin
                    w_state_d = StHalted;
                end
            end
            StHalted: begin
                if (halt_req) begin
                    w_state_d = StIdle;
                end else if (w_accept) begin
                    w_state_d = (load_len == 32'd0) ? StSettle : StLoad;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_len   <= '0;
            r_words <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_din   <= '0;
        end else begin
            r_state <= w_state_d;
            r_run   <= (w_state_d == StRun);
            r_busy  <= (w_state_d == StLoad) || (w_state_d == StSettle);
            r_done  <= (r_state == StRun) && (w_state_d == StHalted);
            r_we    <= w_xfer;

            if (w_xfer) begin
                r_addr  <= w_wr_addr;
                r_din   <= s_data;
                r_words <= w_words_inc;
            end

            if (w_start_ok) begin
                if (w_too_long) begin
                    r_err <= 1'b1;
                end else begin
                    r_err   <= 1'b0;
                    r_words <= '0;
                    r_len   <= load_len[DEPTH:0];
                end
            end

            if ((w_state_d == StSettle) && (r_state != StSettle)) begin
                r_cnt <= CntW'(SETTLE - 1);
            end else if ((r_state == StSettle) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

    assign s_ready      = w_ready;
    assign insn_addr    = r_addr;
    assign insn_din     = r_din;
    assign insn_we      = r_we;
    assign run          = r_run;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: stimulus queues expected imem writes,
// a negedge monitor pops and compares them; control outputs checked inline.
module tb_imem_boot_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [31:0] load_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        halt_req;
    logic        core_done;
    logic [31:0] insn_addr;
    logic [31:0] insn_din;
    logic        insn_we;
    logic        run;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    imem_boot_ctrl #(
        .BASE_ADDR (BASE),
        .DEPTH     (12),
        .SETTLE    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_len     (load_len),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .halt_req     (halt_req),
        .core_done    (core_done),
        .insn_addr    (insn_addr),
        .insn_din     (insn_din),
        .insn_we      (insn_we),
        .run          (run),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Write monitor: every imem write must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && insn_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                         insn_addr, insn_din);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", insn_addr, e[63:32]);
                check("wr_data", insn_din, e[31:0]);
                check("we_while_run", {31'd0, run}, 32'd0);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        halt_req   = 1'b0;
        core_done  = 1'b0;

        #2;
        check("rst_run",   {31'd0, run}, 32'd0);
        check("rst_we",    {31'd0, insn_we}, 32'd0);
        check("rst_addr",  insn_addr, BASE);
        check("rst_din",   insn_din, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_words", {19'd0, words_loaded}, 32'd0);
        check("rst_ready", {31'd0, s_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Normal load of three words, stream held valid.
        load_start = 1'b1; load_len = 32'd3;
        tick();
        load_start = 1'b0;
        check("load_busy",  {31'd0, busy}, 32'd1);
        check("load_ready", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1; s_data = 32'hAAAA_0001; push_wr(BASE, 32'hAAAA_0001);
        tick();
        check("first_wr_we", {31'd0, insn_we}, 32'd1);
        s_data = 32'hBBBB_0002; push_wr(BASE + 32'd4, 32'hBBBB_0002);
        tick();
        s_data = 32'hCCCC_0003; push_wr(BASE + 32'd8, 32'hCCCC_0003);
        tick();
        s_valid = 1'b0;
        check("n3_ready_low", {31'd0, s_ready}, 32'd0);
        check("n3_words", {19'd0, words_loaded}, 32'd3);
        check("n3_run_at_last_wr", {31'd0, run}, 32'd0);
        tick();
        check("n3_run_settle1", {31'd0, run}, 32'd0);
        tick();
        check("n3_run_up", {31'd0, run}, 32'd1);
        check("n3_busy_run", {31'd0, busy}, 32'd0);

        // Completion pulse, then reload a single word.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("cd_run", {31'd0, run}, 32'd0);
        check("cd_done", {31'd0, done}, 32'd1);
        tick();
        check("cd_done_pulse", {31'd0, done}, 32'd0);
        load_start = 1'b1; load_len = 32'd1;
        tick();
        load_start = 1'b0;
        check("reload_busy", {31'd0, busy}, 32'd1);
        s_valid = 1'b1; s_data = 32'hDDDD_0004; push_wr(BASE, 32'hDDDD_0004);
        tick();
        s_valid = 1'b0;
        check("reload_words", {19'd0, words_loaded}, 32'd1);
        tick();
        tick();
        check("reload_run", {31'd0, run}, 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_run", {31'd0, run}, 32'd0);
        check("halt_no_done", {31'd0, done}, 32'd0);

        // Stalled stream, valid pattern 1,0,0,1.
        load_start = 1'b1; load_len = 32'd2;
        tick();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'hEEEE_0005; push_wr(BASE, 32'hEEEE_0005);
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        check("stall_ready_mid", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1; s_data = 32'hFFFF_0006; push_wr(BASE + 32'd4, 32'hFFFF_0006);
        tick();
        s_valid = 1'b0;
        check("stall_ready_low", {31'd0, s_ready}, 32'd0);
        check("stall_words", {19'd0, words_loaded}, 32'd2);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("settle_halt_busy", {31'd0, busy}, 32'd0);

        // Over-length request is rejected without writes.
        load_start = 1'b1; load_len = 32'd4097;
        tick();
        load_start = 1'b0;
        check("ovl_err", {31'd0, err}, 32'd1);
        check("ovl_busy", {31'd0, busy}, 32'd0);
        check("ovl_words", {19'd0, words_loaded}, 32'd2);
        tick();
        check("ovl_no_we", {31'd0, insn_we}, 32'd0);

        // Valid load clears err; abort after 5 of 10 words.
        load_start = 1'b1; load_len = 32'd10;
        tick();
        load_start = 1'b0;
        check("abort_err_clr", {31'd0, err}, 32'd0);
        check("abort_words0", {19'd0, words_loaded}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h1000_0000 + 32'(i);
            push_wr(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i));
            tick();
        end
        s_valid  = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("abort_words", {19'd0, words_loaded}, 32'd5);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, s_ready}, 32'd0);
        repeat (3) tick();
        check("abort_no_run", {31'd0, run}, 32'd0);

        // Zero-length load, then halt_req and core_done together in RUN.
        load_start = 1'b1; load_len = 32'd0;
        tick();
        load_start = 1'b0;
        tick();
        tick();
        check("zl_run", {31'd0, run}, 32'd1);
        halt_req = 1'b1; core_done = 1'b1;
        tick();
        halt_req = 1'b0; core_done = 1'b0;
        check("both_run", {31'd0, run}, 32'd0);
        check("both_no_done", {31'd0, done}, 32'd0);
        tick();
        check("both_no_done2", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of a load.
        load_start = 1'b1; load_len = 32'd4;
        tick();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'h5555_0007; push_wr(BASE, 32'h5555_0007);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_we",    {31'd0, insn_we}, 32'd0);
        check("arst_addr",  insn_addr, BASE);
        check("arst_din",   insn_din, 32'd0);
        check("arst_words", {19'd0, words_loaded}, 32'd0);
        check("arst_busy",  {31'd0, busy}, 32'd0);
        check("arst_run",   {31'd0, run}, 32'd0);
        check("arst_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        load_start = 1'b1; load_len = 32'd0;
        tick();
        load_start = 1'b0;
        check("post_rst_run_a", {31'd0, run}, 32'd0);
        tick();
        check("post_rst_run_b", {31'd0, run}, 32'd0);
        tick();
        check("post_rst_run_c", {31'd0, run}, 32'd1);

        tick();
        check("wr_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
